// File: rtl/key_bounce_gen.sv
// key_bounce_gen: emulated mechanical key, active-low line with press bounce, hold, release bounce.
// Latency: key_out falls and busy rises one edge after press_req is accepted; done pulses on return to IDLE.
// Backpressure: press_req is only honoured in IDLE; requests while busy are dropped. Option: KEY_BOUNCE_LFSR_EN.
module key_bounce_gen #(
  parameter logic [3:0]  BOUNCE_NUM = 4'd3,
  parameter logic [15:0] SEG_CYC    = 16'd2500
`ifdef KEY_BOUNCE_LFSR_EN
  , parameter logic [15:0] LFSR_MASK = 16'h0FFF
`endif
) (
  input  logic        clk_50,
  input  logic        rst,
  input  logic        press_req,
  input  logic [23:0] hold_cycles,
  output logic        key_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, P_BNC, HOLD, R_BNC} state_t;

  // Index of the final segment of a bounce burst (meaningless when there is no burst).
  localparam logic [4:0] LAST_IDX = 5'(2 * int'(BOUNCE_NUM) - 1);
  localparam bit         NO_BNC   = (BOUNCE_NUM == 4'd0);

  state_t      state;
  logic [15:0] seg_cnt;   // cycles remaining in the current segment, minus one
  logic [4:0]  bnc_idx;   // segment number within the current burst
  logic [23:0] hold_cnt;  // cycles remaining in HOLD, minus one
  logic [23:0] hold_lat;  // hold_cycles captured at acceptance
  logic [15:0] seg_load;  // reload value for seg_cnt at the start of each segment

  // A zero hold request still gives one stable-low cycle.
  function automatic logic [23:0] hold_m1(input logic [23:0] h);
    return (h == 24'd0) ? 24'd0 : h - 24'd1;
  endfunction

`ifdef KEY_BOUNCE_LFSR_EN
  logic [15:0] lfsr;
  logic        seg_start;

  assign seg_load = lfsr & LFSR_MASK;

  // Flags every cycle in which a new bounce segment is loaded, so the LFSR steps once per segment.
  always_comb begin
    seg_start = 1'b0;
    case (state)
      IDLE:         seg_start = press_req && !NO_BNC;
      P_BNC, R_BNC: seg_start = (seg_cnt == 16'd0) && (bnc_idx != LAST_IDX);
      HOLD:         seg_start = (hold_cnt == 24'd0) && !NO_BNC;
      default:      seg_start = 1'b0;
    endcase
  end

  // Fibonacci LFSR, taps 16,14,13,11; fixed seed keeps runs repeatable after reset.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else if (seg_start) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end
`else
  assign seg_load = SEG_CYC - 16'd1;
`endif

  assign busy = (state != IDLE);

  // Sequencer: key_out is updated together with the state so it only changes on segment boundaries.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      key_out  <= 1'b1;
      done     <= 1'b0;
      seg_cnt  <= 16'd0;
      bnc_idx  <= 5'd0;
      hold_cnt <= 24'd0;
      hold_lat <= 24'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (press_req) begin
            hold_lat <= hold_cycles;
            key_out  <= 1'b0;
            if (NO_BNC) begin
              state    <= HOLD;
              hold_cnt <= hold_m1(hold_cycles);
            end else begin
              state   <= P_BNC;
              bnc_idx <= 5'd0;
              seg_cnt <= seg_load;
            end
          end
        end
        P_BNC: begin
          if (seg_cnt != 16'd0) begin
            seg_cnt <= seg_cnt - 16'd1;
          end else if (bnc_idx == LAST_IDX) begin
            state    <= HOLD;
            hold_cnt <= hold_m1(hold_lat);
            key_out  <= 1'b0;
          end else begin
            // Press burst starts low: even segments low, odd segments high.
            bnc_idx <= bnc_idx + 5'd1;
            seg_cnt <= seg_load;
            key_out <= ~bnc_idx[0];
          end
        end
        HOLD: begin
          if (hold_cnt != 24'd0) begin
            hold_cnt <= hold_cnt - 24'd1;
          end else if (NO_BNC) begin
            state   <= IDLE;
            done    <= 1'b1;
            key_out <= 1'b1;
          end else begin
            state   <= R_BNC;
            bnc_idx <= 5'd0;
            seg_cnt <= seg_load;
            key_out <= 1'b1;
          end
        end
        R_BNC: begin
          if (seg_cnt != 16'd0) begin
            seg_cnt <= seg_cnt - 16'd1;
          end else if (bnc_idx == LAST_IDX) begin
            state   <= IDLE;
            done    <= 1'b1;
            key_out <= 1'b1;
          end else begin
            // Release burst starts high: even segments high, odd segments low.
            bnc_idx <= bnc_idx + 5'd1;
            seg_cnt <= seg_load;
            key_out <= bnc_idx[0];
          end
        end
        default: begin
          state   <= IDLE;
          key_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/key_bounce_gen.md
# key_bounce_gen

Synthesizable mechanical-key emulator: on a one-cycle request, drives an active-low key line through a press bounce burst, a stable hold, and a release bounce burst, then returns high. It is the driving side of the key-debounce path. Board self-test uses it to feed debouncers and key-handling logic without physical buttons. It also gives benches a realistic, repeatable key stimulus.

## Interface
- BOUNCE_NUM, default 4'd3: bounce pairs on press and on release, 0..15; 0 means a clean edge.
- SEG_CYC, default 16'd2500: cycles per bounce segment, 50 us at 50 MHz. Legal range is 1..65535.
- LFSR_MASK, default 16'h0FFF: segment-length mask used only when KEY_BOUNCE_LFSR_EN is defined.
- clk_50  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous, active-high reset.
- press_req  input  1  start-of-press pulse. Sampled only in IDLE.
- hold_cycles  input  24  stable-low duration in cycles, latched when press_req is accepted. A value of 0 is treated as 1.
- key_out  output  1  emulated key line, active low, idle high. Registered.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse when the sequence completes.

## Operation
- States: IDLE, P_BNC, HOLD, R_BNC.
- IDLE:
  - key_out=1, busy=0.
  - press_req=1 latches hold_cycles, loads the segment counter and bounce index, and moves to P_BNC. If BOUNCE_NUM=0, it moves straight to HOLD.
- P_BNC:
  - 2·BOUNCE_NUM segments alternating low, high, low, high…, starting low.
  - After the last (high) segment, moves to HOLD.
- HOLD: key_out=0 for max(hold_cycles,1) cycles, then moves to R_BNC, or straight to IDLE if BOUNCE_NUM=0.
- R_BNC:
  - 2·BOUNCE_NUM segments alternating high, low…, starting high.
  - After the last (low) segment, moves to IDLE.
- done is pulsed on the cycle the state becomes IDLE. In that same cycle key_out=1 and busy=0.
- press_req while busy is ignored, with no queuing.
- Segment counter: 16-bit down-counter. Bounce index: 5-bit, counts 0..2·BOUNCE_NUM−1. Hold counter: 24-bit.
- key_out is a registered function of state and segment parity. It never glitches within a segment.

## Timing
- Reset values: key_out=1, busy=0, done=0, state=IDLE. Counters and latched hold are 0. LFSR is seeded to 16'hACE1.
- For press_req high at edge T:
  - key_out falls and busy rises at edge T+1.
  - Each segment lasts exactly its length in cycles.
  - Total busy length (fixed segments) is 4·BOUNCE_NUM·SEG_CYC + max(hold_cycles,1) cycles.
  - done is high for the single cycle immediately after the last busy cycle.
- Asserting rst mid-sequence forces the reset values immediately, asynchronously. No done is emitted. The sequence restarts only on a new press_req after rst deasserts.
- A press_req in the same cycle done is high is accepted, because the state is already IDLE. key_out then falls again on the next edge.

## Configuration
- KEY_BOUNCE_LFSR_EN defined:
  - Each bounce segment length is (lfsr & LFSR_MASK) + 1, sampled at segment load.
  - The 16-bit Fibonacci LFSR uses taps 16,14,13,11 and advances once per segment load.
  - The sequence is deterministic after reset.
  - HOLD length is unaffected.
- KEY_BOUNCE_LFSR_EN undefined: every segment lasts exactly SEG_CYC. No LFSR logic is synthesized.

## Test plan
- Reset, then idle for 100 cycles. Required: key_out=1, busy=0, done=0 throughout.
- BOUNCE_NUM=2, SEG_CYC=4, hold_cycles=10, press_req at T.
  - key_out from T+1: 0×4, 1×4, 0×4, 1×4, 0×10, 1×4, 0×4, 1×4, 0×4, then 1.
  - busy is high for 42 cycles.
  - done is high only at T+43.
- BOUNCE_NUM=0, hold_cycles=0. Required: key_out low for exactly 1 cycle, then done on the following cycle.
- Extra press_req pulses during busy, then one in the done cycle. Required: busy-time pulses are ignored. The done-cycle pulse starts a new sequence, with key_out low at the next edge.
- rst asserted mid-HOLD. Required: key_out=1 and busy=0 immediately, and no done pulse. A fresh press_req then runs a complete, correct sequence.
- With KEY_BOUNCE_LFSR_EN, LFSR_MASK=16'h000F:
  - All segment lengths fall within 1..16.
  - Two runs from reset give identical key_out traces.
  - Total duration matches the sum of the logged segment lengths plus hold.
